// File: rtl/ahb_lite_protocol_checker.sv
// rtl/ahb_lite_protocol_checker.sv - passive AHB-Lite rule checker with burst tracking; optional rule [3] under AHB_CHK_WAIT_STABLE_EN
module ahb_lite_protocol_checker #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     hclk,
  input  logic                     hreset,
  input  logic [ADDR_WIDTH-1:0]    haddr,
  input  logic [1:0]               htrans,
  input  logic [2:0]               hburst,
  input  logic [2:0]               hsize,
  input  logic                     hwrite,
  input  logic                     hready,
  input  logic                     hresp,
  input  logic                     err_clr,
  output logic [7:0]               err_vec,
  output logic [7:0]               err_sticky,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt,
  output logic                     burst_active,
  output logic [4:0]               beat_cnt
);

  localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);
  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  typedef enum logic {NO_BURST, IN_BURST} state_t;

  state_t                  state_q, state_d;
  logic [4:0]              beat_q, beat_d;
  logic [4:0]              len_q, len_d;
  logic [ADDR_WIDTH-1:0]   exp_q, exp_d;
  logic [ADDR_WIDTH-11:0]  first_q, first_d;
  logic [2:0]              bsize_q, bsize_d;
  logic                    bwrap_q, bwrap_d;
  logic [1:0]              blg_q, blg_d;
  logic                    done_q, done_d;
  logic                    resp_q;
  logic [7:0]              rules;
  logic [7:0]              align_mask;
  logic                    wait_viol;
  logic                    accepted, in_burst, exempt;

  // Next beat address: linear step for INCR kinds, wrap inside a len*size window for WRAP kinds.
  // lg is hburst[2:1], so the window is size << (lg+1) bytes.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [2:0]            sz,
    input logic                  is_wrap,
    input logic [1:0]            lg
  );
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] mask;
    step = ADDR_WIDTH'(1) << sz;
    mask = (step << (3'(lg) + 3'd1)) - ADDR_WIDTH'(1);
    if (is_wrap) return (a & ~mask) | ((a + step) & mask);
    return a + step;
  endfunction

`ifdef AHB_CHK_WAIT_STABLE_EN
  logic [ADDR_WIDTH-1:0] prev_addr;
  logic [1:0]            prev_trans;
  logic [2:0]            prev_size, prev_burst;
  logic                  prev_write, prev_ready;

  // Shadow of last cycle's control fields for the wait-state stability rule.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      prev_addr  <= '0;
      prev_trans <= T_IDLE;
      prev_size  <= '0;
      prev_burst <= '0;
      prev_write <= 1'b0;
      prev_ready <= 1'b1;
    end else begin
      prev_addr  <= haddr;
      prev_trans <= htrans;
      prev_size  <= hsize;
      prev_burst <= hburst;
      prev_write <= hwrite;
      prev_ready <= hready;
    end
  end

  // A transfer stalled by the slave on the previous edge must be re-presented unchanged;
  // when the previous cycle was already accepted a new transfer may legally appear.
  always_comb begin
    wait_viol = 1'b0;
    if (!hready && !prev_ready && prev_trans[1] &&
        ((haddr != prev_addr) || (hsize != prev_size) || (hwrite != prev_write) ||
         (hburst != prev_burst) ||
         ((htrans != prev_trans) && !(prev_trans == T_BUSY && htrans == T_SEQ))))
      wait_viol = 1'b1;
  end
`else
  logic unused_hwrite;
  assign unused_hwrite = hwrite;
  assign wait_viol     = 1'b0;
`endif

  // Rule evaluation on the sampled bus; every rule except [3] looks only at sampled (hready=1) cycles.
  always_comb begin
    rules      = '0;
    accepted   = hready && htrans[1];
    in_burst   = (state_q == IN_BURST);
    exempt     = hresp || resp_q;
    align_mask = (8'd1 << hsize) - 8'd1;
    rules[0] = accepted && (|(haddr[7:0] & align_mask));
    rules[1] = accepted && (hsize > 3'(MAX_SIZE));
    // A BUSY with SINGLE is reported by [6] only, so [2] skips it.
    rules[2] = hready && !in_burst &&
               ((htrans == T_SEQ) || (htrans == T_BUSY && hburst != 3'd0));
    rules[3] = wait_viol;
    rules[4] = hready && in_burst && (htrans == T_SEQ) && (haddr != exp_q);
    rules[5] = hready && ((in_burst && (len_q != 5'd0) && !exempt &&
                           ((htrans == T_NONSEQ) || (htrans == T_IDLE))) ||
                          ((htrans == T_SEQ) && done_q));
    rules[6] = hready && (htrans == T_BUSY) && (hburst == 3'd0);
    rules[7] = hready && in_burst && (htrans == T_SEQ) && !bwrap_q &&
               (haddr[ADDR_WIDTH-1:10] != first_q);
  end

  // Burst tracker next state: load on NONSEQ, advance on SEQ, drop on IDLE or completion.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    len_d   = len_q;
    exp_d   = exp_q;
    first_d = first_q;
    bsize_d = bsize_q;
    bwrap_d = bwrap_q;
    blg_d   = blg_q;
    done_d  = done_q;
    if (hready && htrans != T_BUSY) done_d = 1'b0;
    if (hready) begin
      if (htrans == T_NONSEQ) begin
        if (hburst != 3'd0) begin
          state_d = IN_BURST;
          beat_d  = 5'd1;
          len_d   = (hburst == 3'd1) ? 5'd0 : (5'd1 << (3'(hburst[2:1]) + 3'd1));
          bwrap_d = !hburst[0];
          blg_d   = hburst[2:1];
          bsize_d = hsize;
          first_d = haddr[ADDR_WIDTH-1:10];
          exp_d   = next_addr(haddr, hsize, !hburst[0], hburst[2:1]);
        end else begin
          state_d = NO_BURST;
          beat_d  = 5'd0;
        end
      end else if (htrans == T_SEQ && in_burst) begin
        beat_d = (beat_q == 5'd31) ? 5'd31 : beat_q + 5'd1;
        exp_d  = next_addr(exp_q, bsize_q, bwrap_q, blg_q);
        if ((len_q != 5'd0) && (beat_q + 5'd1 == len_q)) begin
          state_d = NO_BURST;
          done_d  = 1'b1;
        end
      end else if (htrans == T_IDLE && in_burst) begin
        state_d = NO_BURST;
      end
    end
  end

  // State, tracking and error reporting registers; err_clr beats a same-cycle increment.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q    <= NO_BURST;
      beat_q     <= '0;
      len_q      <= '0;
      exp_q      <= '0;
      first_q    <= '0;
      bsize_q    <= '0;
      bwrap_q    <= 1'b0;
      blg_q      <= '0;
      done_q     <= 1'b0;
      resp_q     <= 1'b0;
      err_vec    <= '0;
      err_sticky <= '0;
      err_cnt    <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      exp_q   <= exp_d;
      first_q <= first_d;
      bsize_q <= bsize_d;
      bwrap_q <= bwrap_d;
      blg_q   <= blg_d;
      done_q  <= done_d;
      resp_q  <= hresp;
      err_vec <= rules;
      if (err_clr) begin
        err_sticky <= '0;
        err_cnt    <= '0;
      end else begin
        err_sticky <= err_sticky | rules;
        if ((|rules) && (err_cnt != '1)) err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
      end
    end
  end

  assign burst_active = (state_q == IN_BURST);
  assign beat_cnt     = beat_q;

endmodule

// File: tb/tb_ahb_lite_protocol_checker.sv
// tb/tb_ahb_lite_protocol_checker.sv - directed and random bench against a behavioural AHB-Lite rule model
module tb_ahb_lite_protocol_checker;

  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NSQ = 2'd2, SEQ = 2'd3;

  logic        hclk = 1'b0;
  logic        hreset;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hburst, hsize;
  logic        hwrite, hready, hresp, err_clr;
  logic [7:0]  err_vec, err_sticky;
  logic [7:0]  err_cnt;
  logic        burst_active;
  logic [4:0]  beat_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int     m_vec, m_sticky, m_cnt, m_len, m_beats;
  bit     m_inb, m_wrap, m_done, m_rprev;
  longint m_exp, m_first, m_size;
  longint p_addr;
  int     p_trans, p_size, p_burst;
  bit     p_write, p_ready;

  ahb_lite_protocol_checker dut (
    .hclk(hclk), .hreset(hreset), .haddr(haddr), .htrans(htrans), .hburst(hburst),
    .hsize(hsize), .hwrite(hwrite), .hready(hready), .hresp(hresp), .err_clr(err_clr),
    .err_vec(err_vec), .err_sticky(err_sticky), .err_cnt(err_cnt),
    .burst_active(burst_active), .beat_cnt(beat_cnt)
  );

  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_vec = 0; m_sticky = 0; m_cnt = 0; m_len = 0; m_beats = 0;
    m_inb = 0; m_wrap = 0; m_done = 0; m_rprev = 0;
    m_exp = 0; m_first = 0; m_size = 1;
    p_addr = 0; p_trans = 0; p_size = 0; p_burst = 0; p_write = 0; p_ready = 1;
  endtask

  function automatic longint nxt(input longint a);
    longint bnd, base;
    if (m_wrap) begin
      bnd  = m_len * m_size;
      base = a - (a % bnd);
      return base + ((a - base + m_size) % bnd);
    end
    return (a + m_size) % 64'h1_0000_0000;
  endfunction

  task automatic model_edge();
    longint a, sz;
    bit     acc;
    int     v;
    a   = longint'(haddr);
    sz  = longint'(1) << hsize;
    acc = hready && (htrans == NSQ || htrans == SEQ);
    v   = 0;
    if (acc && (a % sz) != 0) v |= 1;
    if (acc && hsize > 2) v |= 2;
    if (hready && !m_inb && (htrans == SEQ || (htrans == BUSY && hburst != 0))) v |= 4;
`ifdef AHB_CHK_WAIT_STABLE_EN
    if (!hready && !p_ready && (p_trans == NSQ || p_trans == SEQ) &&
        (a != p_addr || hsize != p_size || hburst != p_burst || hwrite != p_write ||
         (htrans != p_trans && !(p_trans == BUSY && htrans == SEQ)))) v |= 8;
`endif
    p_addr = a; p_trans = htrans; p_size = hsize; p_burst = hburst; p_write = hwrite; p_ready = hready;
    if (hready && m_inb && htrans == SEQ && a != m_exp) v |= 16;
    if (hready && ((m_inb && m_len > 0 && (htrans == NSQ || htrans == IDLE) && !hresp && !m_rprev) ||
                   (htrans == SEQ && m_done))) v |= 32;
    if (hready && htrans == BUSY && hburst == 0) v |= 64;
    if (hready && m_inb && htrans == SEQ && !m_wrap && (a >> 10) != (m_first >> 10)) v |= 128;
    m_vec = v;
    if (err_clr) begin
      m_sticky = 0; m_cnt = 0;
    end else begin
      m_sticky |= v;
      if (v != 0 && m_cnt < 255) m_cnt++;
    end
    if (hready && htrans != BUSY) m_done = 0;
    if (hready) begin
      if (htrans == NSQ) begin
        if (hburst != 0) begin
          m_inb = 1; m_beats = 1;
          m_len  = (hburst == 1) ? 0 : (4 << ((hburst >> 1) - 1));
          m_wrap = (hburst % 2 == 0);
          m_size = sz; m_first = a;
          m_exp  = nxt(a);
        end else begin
          m_inb = 0; m_beats = 0;
        end
      end else if (htrans == SEQ && m_inb) begin
        m_beats = (m_beats < 31) ? m_beats + 1 : 31;
        m_exp   = nxt(m_exp);
        if (m_len > 0 && m_beats == m_len) begin
          m_inb = 0; m_done = 1;
        end
      end else if (htrans == IDLE && m_inb) begin
        m_inb = 0;
      end
    end
    m_rprev = hresp;
  endtask

  // One bus cycle: drive at the falling edge, model at the rising edge, compare 1 ns later.
  task automatic bus_cycle(input logic [1:0] t, input logic [31:0] a, input logic [2:0] b,
                           input logic [2:0] s, input logic rdy, input logic rsp, input logic clr);
    htrans = t; haddr = a; hburst = b; hsize = s; hready = rdy; hresp = rsp; err_clr = clr;
    @(posedge hclk);
    model_edge();
    #1;
    check("err_vec", err_vec, 32'(m_vec));
    check("err_sticky", err_sticky, 32'(m_sticky));
    check("err_cnt", err_cnt, 32'(m_cnt));
    check("burst_active", burst_active, 32'(m_inb));
    check("beat_cnt", beat_cnt, 32'(m_beats));
    @(negedge hclk);
  endtask

  initial begin
    logic [1:0]  rt;
    logic [31:0] ra;
    model_reset();
    hreset = 1'b1; haddr = '0; htrans = IDLE; hburst = '0; hsize = '0;
    hwrite = 1'b0; hready = 1'b1; hresp = 1'b0; err_clr = 1'b0;
    repeat (2) @(negedge hclk);
    check("rst_err_vec", err_vec, 0);
    check("rst_sticky", err_sticky, 0);
    check("rst_cnt", err_cnt, 0);
    check("rst_active", burst_active, 0);
    check("rst_beat", beat_cnt, 0);
    hreset = 1'b0;

    // INCR4 clean burst
    bus_cycle(NSQ, 32'h100, 3'd3, 3'd2, 1, 0, 0);
    check("incr4_b1", beat_cnt, 1);
    for (int i = 1; i < 4; i++) begin
      bus_cycle(SEQ, 32'h100 + 32'(4 * i), 3'd3, 3'd2, 1, 0, 0);
      check("incr4_beat", beat_cnt, 32'(i + 1));
      check("incr4_clean", err_vec, 0);
    end
    check("incr4_end", burst_active, 0);
    bus_cycle(IDLE, 0, 0, 0, 1, 0, 0);

    // WRAP4 from 0x38 with a wrong second beat
    bus_cycle(NSQ, 32'h38, 3'd2, 3'd2, 1, 0, 0);
    bus_cycle(SEQ, 32'h40, 3'd2, 3'd2, 1, 0, 0);
    check("wrap_addr_err", err_vec, 32'h10);
    check("wrap_cnt", err_cnt, 1);
    bus_cycle(SEQ, 32'h30, 3'd2, 3'd2, 1, 0, 0);
    check("wrap_b3", err_vec, 0);
    bus_cycle(SEQ, 32'h34, 3'd2, 3'd2, 1, 0, 0);
    check("wrap_b4", err_vec, 0);
    bus_cycle(IDLE, 0, 0, 0, 1, 0, 1);

    // INCR8 cut short, then cut short after an ERROR response
    bus_cycle(NSQ, 32'h200, 3'd5, 3'd2, 1, 0, 0);
    bus_cycle(SEQ, 32'h204, 3'd5, 3'd2, 1, 0, 0);
    bus_cycle(SEQ, 32'h208, 3'd5, 3'd2, 1, 0, 0);
    bus_cycle(NSQ, 32'h300, 3'd0, 3'd2, 1, 0, 0);
    check("incr8_len_err", err_vec, 32'h20);
    bus_cycle(NSQ, 32'h200, 3'd5, 3'd2, 1, 0, 0);
    bus_cycle(SEQ, 32'h204, 3'd5, 3'd2, 1, 0, 0);
    bus_cycle(SEQ, 32'h208, 3'd5, 3'd2, 1, 1, 0);
    bus_cycle(NSQ, 32'h300, 3'd0, 3'd2, 1, 0, 0);
    check("incr8_resp_ok", err_vec, 0);
    bus_cycle(IDLE, 0, 0, 0, 1, 0, 1);

    // Misaligned single then BUSY on SINGLE, then clear
    bus_cycle(NSQ, 32'h102, 3'd0, 3'd2, 1, 0, 0);
    check("misalign", err_vec, 32'h01);
    bus_cycle(BUSY, 32'h102, 3'd0, 3'd2, 1, 0, 0);
    check("single_busy", err_vec, 32'h40);
    check("sticky41", err_sticky, 32'h41);
    check("cnt2", err_cnt, 2);
    bus_cycle(IDLE, 0, 0, 0, 1, 0, 1);
    check("clr_sticky", err_sticky, 0);
    check("clr_cnt", err_cnt, 0);

    // Address changed during a wait state
    bus_cycle(NSQ, 32'h200, 3'd0, 3'd2, 0, 0, 0);
    bus_cycle(NSQ, 32'h204, 3'd0, 3'd2, 0, 0, 0);
`ifdef AHB_CHK_WAIT_STABLE_EN
    check("wait_stable", err_vec, 32'h08);
`else
    check("wait_stable", err_vec, 32'h00);
`endif
    bus_cycle(NSQ, 32'h204, 3'd0, 3'd2, 1, 0, 0);
    bus_cycle(IDLE, 0, 0, 0, 1, 0, 1);

    // Full INCR16 then one SEQ too many
    bus_cycle(NSQ, 32'h0, 3'd7, 3'd2, 1, 0, 0);
    for (int i = 1; i < 16; i++) bus_cycle(SEQ, 32'(4 * i), 3'd7, 3'd2, 1, 0, 0);
    check("incr16_beats", beat_cnt, 16);
    check("incr16_done", burst_active, 0);
    bus_cycle(SEQ, 32'h40, 3'd7, 3'd2, 1, 0, 0);
    check("seq_after_last", err_vec, 32'h24);
    bus_cycle(IDLE, 0, 0, 0, 1, 0, 1);

    // Undefined-length INCR saturates beat_cnt
    bus_cycle(NSQ, 32'h800, 3'd1, 3'd0, 1, 0, 0);
    for (int i = 1; i < 40; i++) bus_cycle(SEQ, 32'h800 + 32'(i), 3'd1, 3'd0, 1, 0, 0);
    check("incr_sat", beat_cnt, 31);
    check("incr_active", burst_active, 1);
    bus_cycle(IDLE, 0, 0, 0, 1, 0, 0);

    // Error counter saturation
    for (int i = 0; i < 300; i++) bus_cycle(NSQ, 32'h102, 3'd0, 3'd2, 1, 0, 0);
    check("cnt_sat", err_cnt, 255);
    bus_cycle(IDLE, 0, 0, 0, 1, 0, 1);

    // Asynchronous reset in the middle of an INCR16
    bus_cycle(NSQ, 32'h400, 3'd7, 3'd2, 1, 0, 0);
    for (int i = 1; i < 5; i++) bus_cycle(SEQ, 32'h400 + 32'(4 * i), 3'd7, 3'd2, 1, 0, 0);
    #2 hreset = 1'b1;
    #1;
    check("arst_active", burst_active, 0);
    check("arst_beat", beat_cnt, 0);
    check("arst_vec", err_vec, 0);
    model_reset();
    @(negedge hclk);
    hreset = 1'b0;
    bus_cycle(SEQ, 32'h414, 3'd7, 3'd2, 1, 0, 0);
    check("post_rst_orphan", err_vec, 32'h04);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if (m_inb && $urandom_range(0, 9) < 6) rt = SEQ;
      else rt = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 1) == 1) ? 32'(m_exp) : ($urandom & 32'h7FF);
      hwrite = 1'($urandom_range(0, 1));
      bus_cycle(rt, ra, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 3)),
                1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 9) == 0),
                1'($urandom_range(0, 19) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
